// File: rtl/host_reset_pkg.sv
// Shared definitions for the host reset sequencer:
// register map, CTRL bit positions and sequencer states.
package host_reset_pkg;

  localparam logic [1:0] REG_CTRL      = 2'd0;
  localparam logic [1:0] REG_PULSE_LEN = 2'd1;
  localparam logic [1:0] REG_RECOVERY  = 2'd2;
  localparam logic [1:0] REG_STATUS    = 2'd3;

  // CTRL write bits
  localparam int CTRL_GO      = 0;
  localparam int CTRL_FORCE   = 1;
  localparam int CTRL_IRQ_CLR = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RECOVER = 2'd2
  } seq_state_e;

  // CTRL read view: b0 BUSY, b1 FORCE, b2 IRQ, b3 PENDING
  function automatic logic [31:0] ctrl_rd(
    input logic busy,
    input logic force_en,
    input logic irq,
    input logic pending
  );
    return {28'd0, pending, irq, force_en, busy};
  endfunction

endpackage

// File: rtl/host_reset_req_sync.sv
// Two-flop synchroniser for the external reset request pin,
// followed by a rising-edge detector producing a 1-cycle pulse.
module host_reset_req_sync
  import host_reset_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic req_pulse
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign req_pulse = sync_q & ~prev_q;

endmodule

// File: rtl/host_reset_sequencer.sv
// Avalon-MM host reset sequencer: timed reset pulse followed by a
// recovery hold-off, triggered by CTRL.GO or a rising edge on ext_req.
module host_reset_sequencer
  import host_reset_pkg::*;
#(
  parameter int unsigned PULSE_DEFAULT = 1000,
  parameter int unsigned RECOV_DEFAULT = 500,
  parameter int          CNT_W         = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        ext_req,
  output logic        host_reset_out,
  output logic        seq_done_irq
);

  seq_state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pulse_len_q, pulse_len_d;
  logic [CNT_W-1:0] recovery_q, recovery_d;
  logic [7:0]       count_q, count_d;
  logic             force_q, force_d;
  logic             pending_q, pending_d;
  logic             irq_q, irq_d;
  logic             out_q, out_d;

  logic wr_en;
  logic wr_ctrl;
  logic wr_pulse;
  logic wr_recov;
  logic go;
  logic ext_pulse;
  logic req;
  logic unused_wd;

  host_reset_req_sync u_req_sync (
    .clk       (clk),
    .reset     (reset),
    .async_in  (ext_req),
    .req_pulse (ext_pulse)
  );

  assign wr_en    = chipselect & ~write_n;
  assign wr_ctrl  = wr_en & (address == REG_CTRL);
  assign wr_pulse = wr_en & (address == REG_PULSE_LEN);
  assign wr_recov = wr_en & (address == REG_RECOVERY);
  assign go       = wr_ctrl & writedata[CTRL_GO];
  assign req      = go | ext_pulse;

  assign unused_wd = ^writedata[31:CNT_W];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pulse_len_d = pulse_len_q;
    recovery_d  = recovery_q;
    count_d     = count_q;
    force_d     = force_q;
    pending_d   = pending_q;
    irq_d       = irq_q;

    if (wr_pulse) pulse_len_d = writedata[CNT_W-1:0];
    if (wr_recov) recovery_d  = writedata[CNT_W-1:0];
    if (wr_ctrl)  force_d     = writedata[CTRL_FORCE];
    if (wr_ctrl && writedata[CTRL_IRQ_CLR]) irq_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req || pending_q) begin
          state_d   = ST_ASSERT;
          pending_d = 1'b0;
          // a zero length still yields a one-cycle pulse
          if (pulse_len_q == '0) cnt_d = '0;
          else cnt_d = pulse_len_q - CNT_W'(1);
        end
      end
      ST_ASSERT: begin
        if (cnt_q == '0) begin
          state_d = ST_RECOVER;
          cnt_d   = recovery_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RECOVER: begin
        if (req) pending_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          count_d = count_q + 8'd1;
          irq_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    out_d = force_d | (state_d == ST_ASSERT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pulse_len_q <= CNT_W'(PULSE_DEFAULT);
      recovery_q  <= CNT_W'(RECOV_DEFAULT);
      count_q     <= 8'd0;
      force_q     <= 1'b0;
      pending_q   <= 1'b0;
      irq_q       <= 1'b0;
      out_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pulse_len_q <= pulse_len_d;
      recovery_q  <= recovery_d;
      count_q     <= count_d;
      force_q     <= force_d;
      pending_q   <= pending_d;
      irq_q       <= irq_d;
      out_q       <= out_d;
    end
  end

  assign host_reset_out = out_q;
  assign seq_done_irq   = irq_q;

  always_comb begin
    readdata = '0;
    unique case (address)
      REG_CTRL:      readdata = ctrl_rd(state_q != ST_IDLE, force_q,
                                        irq_q, pending_q);
      REG_PULSE_LEN: readdata = 32'(pulse_len_q);
      REG_RECOVERY:  readdata = 32'(recovery_q);
      REG_STATUS:    readdata = {24'd0, count_q};
      default:       readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_host_reset_sequencer.sv
// Directed bench for host_reset_sequencer with a queue-based scoreboard.
module tb_host_reset_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        ext_req = 1'b0;
  logic        host_reset_out;
  logic        seq_done_irq;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  host_reset_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .address        (address),
    .chipselect     (chipselect),
    .write_n        (write_n),
    .writedata      (writedata),
    .readdata       (readdata),
    .ext_req        (ext_req),
    .host_reset_out (host_reset_out),
    .seq_done_irq   (seq_done_irq)
  );

  always #5 clk = ~clk;

  task automatic expect_val(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic compare(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", t, obs, e);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    #1;
    d          = readdata;
    chipselect = 1'b0;
  endtask

  // Count cycles with BUSY set and with the reset output high.
  task automatic measure(output int hi, output int busy);
    logic [31:0] c;
    bit          done;
    hi   = 0;
    busy = 0;
    done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      rd(2'd0, c);
      if (c[0]) begin
        busy++;
        if (host_reset_out) hi++;
        @(negedge clk);
      end else begin
        done = 1;
      end
    end
    if (!done) begin
      expect_val("busy_timeout", 32'd0);
      compare(32'd1);
    end
  endtask

  initial begin
    logic [31:0] d;
    int hi, busy;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // reset state
    expect_val("rst_pulse_len", 32'd1000); rd(2'd1, d); compare(d);
    expect_val("rst_recovery", 32'd500);   rd(2'd2, d); compare(d);
    expect_val("rst_ctrl", 32'd0);         rd(2'd0, d); compare(d);
    expect_val("rst_out", 32'd0);          compare(32'(host_reset_out));

    // basic sequence 5/3, upper PULSE_LEN bits ignored
    wr(2'd1, 32'hFFFF_0005);
    wr(2'd2, 32'd3);
    expect_val("pulse_len_rd", 32'd5); rd(2'd1, d); compare(d);
    wr(2'd0, 32'd1);
    measure(hi, busy);
    exp_count++;
    expect_val("seq1_hi", 32'd5);   compare(32'(hi));
    expect_val("seq1_busy", 32'd9); compare(32'(busy));
    expect_val("seq1_ctrl", 32'd4); rd(2'd0, d); compare(d);
    expect_val("seq1_status", 32'(exp_count)); rd(2'd3, d); compare(d);
    wr(2'd0, 32'd4);
    expect_val("irq_clr_ctrl", 32'd0); rd(2'd0, d); compare(d);
    expect_val("irq_clr_pin", 32'd0);  compare(32'(seq_done_irq));

    // zero lengths: 1-cycle pulse, 1-cycle recovery
    wr(2'd1, 32'd0);
    wr(2'd2, 32'd0);
    wr(2'd0, 32'd1);
    measure(hi, busy);
    exp_count++;
    expect_val("zero_hi", 32'd1);   compare(32'(hi));
    expect_val("zero_busy", 32'd2); compare(32'(busy));
    expect_val("zero_status", 32'(exp_count)); rd(2'd3, d); compare(d);
    wr(2'd0, 32'd4);

    // ext_req rising during RECOVER -> pending second sequence
    wr(2'd1, 32'd5);
    wr(2'd2, 32'd3);
    wr(2'd0, 32'd1);
    repeat (4) @(negedge clk);
    ext_req = 1'b1;
    repeat (3) @(negedge clk);
    expect_val("pend_ctrl", 32'd9); rd(2'd0, d); compare(d);
    ext_req = 1'b0;
    repeat (2) @(negedge clk);
    exp_count++;
    expect_val("pend_idle_ctrl", 32'd12); rd(2'd0, d); compare(d);
    @(negedge clk);
    measure(hi, busy);
    exp_count++;
    expect_val("pend_hi", 32'd5);   compare(32'(hi));
    expect_val("pend_busy", 32'd9); compare(32'(busy));
    expect_val("pend_status", 32'(exp_count)); rd(2'd3, d); compare(d);
    wr(2'd0, 32'd4);

    // ext_req rising during ASSERT -> absorbed
    wr(2'd0, 32'd1);
    ext_req = 1'b1;
    measure(hi, busy);
    exp_count++;
    expect_val("absorb_hi", 32'd5);   compare(32'(hi));
    expect_val("absorb_busy", 32'd9); compare(32'(busy));
    repeat (3) @(negedge clk);
    expect_val("absorb_ctrl", 32'd4); rd(2'd0, d); compare(d);
    expect_val("absorb_status", 32'(exp_count)); rd(2'd3, d); compare(d);
    ext_req = 1'b0;
    wr(2'd0, 32'd4);

    // FORCE while idle
    wr(2'd0, 32'd2);
    expect_val("force_out", 32'd1);  compare(32'(host_reset_out));
    expect_val("force_ctrl", 32'd2); rd(2'd0, d); compare(d);
    repeat (4) @(negedge clk);
    expect_val("force_hold", 32'd1); compare(32'(host_reset_out));
    wr(2'd0, 32'd0);
    expect_val("force_off", 32'd0);  compare(32'(host_reset_out));

    // async reset mid-ASSERT
    wr(2'd1, 32'd100);
    wr(2'd0, 32'd1);
    repeat (40) @(negedge clk);
    expect_val("mid_out", 32'd1); compare(32'(host_reset_out));
    #2 reset = 1'b1;
    #1;
    expect_val("arst_out", 32'd0); compare(32'(host_reset_out));
    @(negedge clk);
    reset = 1'b0;
    exp_count = 0;
    expect_val("arst_pulse", 32'd1000); rd(2'd1, d); compare(d);
    expect_val("arst_recov", 32'd500);  rd(2'd2, d); compare(d);
    expect_val("arst_ctrl", 32'd0);     rd(2'd0, d); compare(d);
    expect_val("arst_status", 32'd0);   rd(2'd3, d); compare(d);
    expect_val("arst_irq", 32'd0);      compare(32'(seq_done_irq));
    repeat (3) @(negedge clk);
    expect_val("arst_hold", 32'd0);     compare(32'(host_reset_out));

    // completed-sequence counter wrap
    wr(2'd1, 32'd0);
    wr(2'd2, 32'd0);
    for (int i = 0; i < 256; i++) begin
      wr(2'd0, 32'd1);
      repeat (2) @(negedge clk);
      exp_count = (exp_count + 1) % 256;
      if (i == 254) begin
        expect_val("status_255", 32'(exp_count)); rd(2'd3, d); compare(d);
      end
    end
    expect_val("status_wrap", 32'(exp_count)); rd(2'd3, d); compare(d);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
